// File: rtl/fir_pkg.sv
// Shared types and sizing helpers for the serial 4-tap FIR datapath.
// Saturation limits are expressed as functions of the output width.
package fir_pkg;

  typedef logic [1:0] tap_idx_t;

  localparam int DW_DEF    = 12;
  localparam int OUT_W_DEF = 16;

  function automatic int acc_w(input int dw);
    return 2 * dw + 2;
  endfunction

  function automatic int sat_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int sat_min(input int w);
    return -(1 << (w - 1));
  endfunction

endpackage

// File: rtl/fir_sat.sv
// Combinational signed saturator from accumulator width to output width.
// ovf flags any clamp in either direction.
module fir_sat
  import fir_pkg::*;
#(
  parameter int IN_W  = acc_w(DW_DEF),
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    ovf
);

  localparam logic signed [IN_W-1:0]  HI  = IN_W'(sat_max(OUT_W));
  localparam logic signed [IN_W-1:0]  LO  = IN_W'(sat_min(OUT_W));
  localparam logic signed [OUT_W-1:0] OHI = OUT_W'(sat_max(OUT_W));
  localparam logic signed [OUT_W-1:0] OLO = OUT_W'(sat_min(OUT_W));

  always_comb begin
    dout = din[OUT_W-1:0];
    ovf  = 1'b0;
    if (din > HI) begin
      dout = OHI;
      ovf  = 1'b1;
    end else if (din < LO) begin
      dout = OLO;
      ovf  = 1'b1;
    end
  end

endmodule

// File: rtl/fir4_mac_datapath.sv
// Serial 4-tap FIR MAC: one tap per cycle, one saturated output per frame.
// Delay line, coefficient file and accumulator live here.
module fir4_mac_datapath
  import fir_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int ACC_W = acc_w(DW)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [DW-1:0]    sample_in,
  input  logic                    sample_strobe,
  input  tap_idx_t                mux_sel,
  input  logic                    clear_accum,
  input  logic                    coef_we,
  input  tap_idx_t                coef_addr,
  input  logic signed [DW-1:0]    coef_data,
  output logic signed [OUT_W-1:0] y_out,
  output logic                    y_valid,
  output logic                    sat_flag
);

  logic signed [DW-1:0]    taps [4];
  logic signed [DW-1:0]    coef [4];
  logic signed [ACC_W-1:0] acc;
  logic signed [2*DW-1:0]  prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] sum;
  logic signed [OUT_W-1:0] sat_y;
  logic                    sat_ovf;

  // Strobe-cycle product still sees the pre-shift taps.
  assign prod     = taps[mux_sel] * coef[mux_sel];
  assign prod_ext = {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
  assign sum      = acc + prod_ext;

  fir_sat #(
    .IN_W  (ACC_W),
    .OUT_W (OUT_W)
  ) u_sat (
    .din  (sum),
    .dout (sat_y),
    .ovf  (sat_ovf)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) taps[i] <= '0;
    end else if (sample_strobe) begin
      taps[3] <= taps[2];
      taps[2] <= taps[1];
      taps[1] <= taps[0];
      taps[0] <= sample_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) coef[i] <= '0;
    end else if (coef_we) begin
      coef[coef_addr] <= coef_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc      <= '0;
      y_out    <= '0;
      y_valid  <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      y_valid <= clear_accum;
      if (clear_accum) begin
        acc      <= '0;
        y_out    <= sat_y;
        sat_flag <= sat_flag | sat_ovf;
      end else begin
        acc <= sum;
      end
    end
  end

endmodule
